// File: rtl/estacionamiento_multicarril.sv
// Multi-lane parking controller: per-lane sync/debounce/direction FSM feeding a shared saturating counter.
// Build option: define ESTAC_RECHAZO_EN to add REJECT[LANES] and refuse entries beyond CAPACITY.

module estac_carril #(
  parameter int DEB_CYCLES = 240000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic sens_a,
  input  logic sens_b,
  output logic fire_ent,
  output logic fire_exit,
  output logic err_ev
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} st_t;
  st_t st;

  logic [1:0] raw, s1, s2, lvl;
  logic [1:0][CW-1:0] cnt;
  logic [1:0] xy;

  assign raw = {sens_a, sens_b} ^ {2{ACTIVE_LOW != 0}};
  // exit states reuse the entry table with a and b swapped
  assign xy  = {lvl[0], lvl[1]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1  <= '0;
      s2  <= '0;
      lvl <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) st <= IDLE;
    else begin
      case (st)
        IDLE: if (lvl == 2'b10) st <= E1; else if (lvl == 2'b01) st <= X1;
        E1:   if (lvl == 2'b11) st <= E2; else if (lvl != 2'b10) st <= IDLE;
        E2:   if (lvl == 2'b01) st <= E3; else if (lvl == 2'b10) st <= E1;
              else if (lvl == 2'b00) st <= IDLE;
        E3:   if (lvl == 2'b11) st <= E2; else if (lvl != 2'b01) st <= IDLE;
        X1:   if (xy == 2'b11) st <= X2; else if (xy != 2'b10) st <= IDLE;
        X2:   if (xy == 2'b01) st <= X3; else if (xy == 2'b10) st <= X1;
              else if (xy == 2'b00) st <= IDLE;
        X3:   if (xy == 2'b11) st <= X2; else if (xy != 2'b01) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign fire_ent  = (st == E3) && (lvl == 2'b00);
  assign fire_exit = (st == X3) && (lvl == 2'b00);
  assign err_ev = ((st == IDLE) && (lvl == 2'b11)) ||
                  ((st == E1) && (lvl == 2'b01)) || ((st == X1) && (xy == 2'b01)) ||
                  ((st == E2) && (lvl == 2'b00)) || ((st == X2) && (xy == 2'b00)) ||
                  ((st == E3) && (lvl == 2'b10)) || ((st == X3) && (xy == 2'b10));
endmodule

module estacionamiento_multicarril #(
  parameter int LANES      = 2,
  parameter int CAPACITY   = 7,
  parameter int CNT_W      = 3,
  parameter int DEB_CYCLES = 240000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [LANES-1:0] SENS_A,
  input  logic [LANES-1:0] SENS_B,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic [LANES-1:0] ENTER_PULSE,
  output logic [LANES-1:0] EXIT_PULSE,
`ifdef ESTAC_RECHAZO_EN
  output logic [LANES-1:0] REJECT,
`endif
  output logic             ERR
);
  localparam int SW = CNT_W + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [LANES-1:0] fire_ent, fire_exit, err_ev, ent_ok;
  logic signed [SW-1:0] sum;
  logic [CNT_W-1:0] cnt_nxt;
  logic sat;

  estac_carril #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_lane [LANES-1:0] (
    .CLK(CLK), .RST_N(RST_N), .sens_a(SENS_A), .sens_b(SENS_B),
    .fire_ent(fire_ent), .fire_exit(fire_exit), .err_ev(err_ev)
  );

`ifdef ESTAC_RECHAZO_EN
  logic signed [SW-1:0] room;
  // entries claim the space left after this cycle's exits, lowest lane first
  always_comb begin
    ent_ok = '0;
    room   = $signed({4'b0, COUNT});
    for (int l = 0; l < LANES; l++) room = room - SW'(fire_exit[l]);
    for (int l = 0; l < LANES; l++)
      if (fire_ent[l] && (room < CAP_S)) begin
        ent_ok[l] = 1'b1;
        room      = room + SW'(1);
      end
  end
`else
  assign ent_ok = fire_ent;
`endif

  always_comb begin
    sum = $signed({4'b0, COUNT});
    for (int l = 0; l < LANES; l++) sum = sum + SW'(ent_ok[l]) - SW'(fire_exit[l]);
    sat     = 1'b0;
    cnt_nxt = sum[CNT_W-1:0];
    if (sum[SW-1]) begin
      sat     = 1'b1;
      cnt_nxt = '0;
    end else if (sum > CAP_S) begin
      sat     = 1'b1;
      cnt_nxt = CNT_W'(CAPACITY);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      COUNT       <= '0;
      ENTER_PULSE <= '0;
      EXIT_PULSE  <= '0;
      ERR         <= 1'b0;
`ifdef ESTAC_RECHAZO_EN
      REJECT      <= '0;
`endif
    end else begin
      COUNT       <= cnt_nxt;
      ENTER_PULSE <= ent_ok;
      EXIT_PULSE  <= fire_exit;
      ERR         <= ERR | (|err_ev) | sat;
`ifdef ESTAC_RECHAZO_EN
      REJECT      <= fire_ent & ~ent_ok;
`endif
    end
  end

  assign FULL  = (COUNT == CNT_W'(CAPACITY));
  assign EMPTY = (COUNT == '0);
endmodule

// File: tb/tb_estacionamiento_multicarril.sv
// Directed + randomized bench for estacionamiento_multicarril against a passage-level occupancy model.
module tb_estacionamiento_multicarril;
  localparam int CAP = 7;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] SENS_A, SENS_B;
  logic [2:0] COUNT;
  logic       FULL, EMPTY, ERR;
  logic [1:0] ENTER_PULSE, EXIT_PULSE;
`ifdef ESTAC_RECHAZO_EN
  logic [1:0] REJECT;
`endif

  estacionamiento_multicarril #(
    .LANES(2), .CAPACITY(CAP), .CNT_W(3), .DEB_CYCLES(4), .ACTIVE_LOW(0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .SENS_A(SENS_A), .SENS_B(SENS_B),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
    .ENTER_PULSE(ENTER_PULSE), .EXIT_PULSE(EXIT_PULSE),
`ifdef ESTAC_RECHAZO_EN
    .REJECT(REJECT),
`endif
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // pulse monitor
  int cyc = 0, n_ent = 0, n_ex = 0, n_rej = 0, n_long = 0, ent0_cyc = -1, ex1_cyc = -2;
  logic [1:0] prev_ent = '0, prev_ex = '0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    n_ent  <= n_ent + $countones(ENTER_PULSE);
    n_ex   <= n_ex + $countones(EXIT_PULSE);
    n_long <= n_long + $countones(ENTER_PULSE & prev_ent) + $countones(EXIT_PULSE & prev_ex);
    prev_ent <= ENTER_PULSE;
    prev_ex  <= EXIT_PULSE;
    if (ENTER_PULSE[0]) ent0_cyc <= cyc;
    if (EXIT_PULSE[1])  ex1_cyc  <= cyc;
`ifdef ESTAC_RECHAZO_EN
    n_rej <= n_rej + $countones(REJECT);
`endif
  end

  // reference model: occupancy tracked per whole passage
  int m_count = 0, m_ent = 0, m_ex = 0, m_rej = 0;
  bit m_err = 0;
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_entry();
`ifdef ESTAC_RECHAZO_EN
    if (m_count >= CAP) m_rej++;
    else begin m_count++; m_ent++; end
`else
    m_ent++;
    if (m_count == CAP) m_err = 1; else m_count++;
`endif
  endtask

  task automatic model_exit();
    m_ex++;
    if (m_count == 0) m_err = 1; else m_count--;
  endtask

  task automatic step(input int lane, input bit a, input bit b, input int n);
    SENS_A[lane] = a;
    SENS_B[lane] = b;
    repeat (n) @(posedge CLK);
  endtask

  task automatic passage(input int lane, input bit is_exit, input int h);
    if (!is_exit) begin
      step(lane, 1, 0, h); step(lane, 1, 1, h); step(lane, 0, 1, h);
    end else begin
      step(lane, 0, 1, h); step(lane, 1, 1, h); step(lane, 1, 0, h);
    end
    step(lane, 0, 0, 10);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    SENS_A = '0;
    SENS_B = '0;
    do_reset();
    chk("reset_count", COUNT, 0);
    chk("reset_empty", EMPTY, 1);
    chk("reset_full", FULL, 0);
    chk("reset_err", ERR, 0);
    chk("reset_pulses", {ENTER_PULSE, EXIT_PULSE}, 0);
    RST_N = 1'b1;

    passage(0, 0, 10); model_entry();
    chk("entry0_pulses", n_ent, 1);
    chk("entry0_count", COUNT, 1);
    chk("entry0_width", n_long, 0);

    for (int i = 0; i < 10; i++) begin
      SENS_A[1] = ~SENS_A[1];
      repeat (2) @(posedge CLK);
    end
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("bounce_pulses", n_ent + n_ex, 1);
    chk("bounce_err", ERR, 0);
    chk("bounce_count", COUNT, 1);

    passage(0, 0, 9); model_entry();
    passage(0, 0, 9); model_entry();
    chk("pre_sim_count", COUNT, 3);
    SENS_A = 2'b01; SENS_B = 2'b10; repeat (10) @(posedge CLK);
    SENS_A = 2'b11; SENS_B = 2'b11; repeat (10) @(posedge CLK);
    SENS_A = 2'b10; SENS_B = 2'b01; repeat (10) @(posedge CLK);
    SENS_A = 2'b00; SENS_B = 2'b00; repeat (10) @(posedge CLK);
    @(negedge CLK);
    m_ent++; m_ex++;
    chk("sim_same_cycle", ent0_cyc, ex1_cyc);
    chk("sim_count", COUNT, 3);
    chk("sim_enter", n_ent, m_ent);
    chk("sim_exit", n_ex, m_ex);
    chk("sim_err", ERR, 0);

    for (int i = 0; i < 8; i++) begin
      passage(0, 0, 8); model_entry();
    end
    chk("sat_count", COUNT, m_count);
    chk("sat_full", FULL, 1);
    chk("sat_empty", EMPTY, 0);
    chk("sat_err", ERR, m_err);
    chk("sat_enter", n_ent, m_ent);
    chk("sat_reject", n_rej, m_rej);

    for (int i = 0; i < 14; i++) begin
      int lane, h;
      bit dir;
      lane = $urandom_range(1, 0);
      dir  = 1'($urandom_range(1, 0));
      h    = $urandom_range(12, 8);
      passage(lane, dir, h);
      if (dir) model_exit(); else model_entry();
      chk("rnd_count", COUNT, m_count);
      chk("rnd_full", FULL, m_count == CAP);
      chk("rnd_empty", EMPTY, m_count == 0);
    end
    chk("rnd_err", ERR, m_err);
    chk("rnd_enter", n_ent, m_ent);
    chk("rnd_exit", n_ex, m_ex);
    chk("rnd_reject", n_rej, m_rej);
    chk("rnd_width", n_long, 0);

    do_reset();
    RST_N = 1'b1;
    m_count = 0; m_err = 0;
    chk("rst2_count", COUNT, 0);
    chk("rst2_err", ERR, 0);
    passage(0, 0, 10); model_entry();
    chk("rst2_entry", COUNT, 1);
    step(1, 1, 1, 10);
    @(negedge CLK);
    chk("idle11_err", ERR, 1);
    step(1, 0, 0, 10);
    step(0, 1, 0, 10);
    step(0, 1, 1, 10);
    do_reset();
    chk("midrst_count", COUNT, 0);
    chk("midrst_err", ERR, 0);
    chk("midrst_empty", EMPTY, 1);
    RST_N = 1'b1;
    step(0, 0, 1, 10);
    step(0, 0, 0, 12);
    @(negedge CLK);
    chk("release_enter", n_ent, m_ent);
    chk("release_exit", n_ex, m_ex);
    chk("release_err", ERR, 0);
    chk("release_count", COUNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
